// File: rtl/sm_debug_viewer_pkg.sv
// Shared seven-segment patterns (active-low, bit order g..a) and debouncer state encoding
// for the debug viewer.
package sm_debug_viewer_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b0000011;
  localparam logic [6:0] SEG_C     = 7'b1000110;
  localparam logic [6:0] SEG_D     = 7'b0100001;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_F     = 7'b0001110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    DB_ARM  = 2'd0,
    DB_UP   = 2'd1,
    DB_DOWN = 2'd2
  } db_state_e;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    case (nib)
      4'h0: hex_to_seg = SEG_0;
      4'h1: hex_to_seg = SEG_1;
      4'h2: hex_to_seg = SEG_2;
      4'h3: hex_to_seg = SEG_3;
      4'h4: hex_to_seg = SEG_4;
      4'h5: hex_to_seg = SEG_5;
      4'h6: hex_to_seg = SEG_6;
      4'h7: hex_to_seg = SEG_7;
      4'h8: hex_to_seg = SEG_8;
      4'h9: hex_to_seg = SEG_9;
      4'hA: hex_to_seg = SEG_A;
      4'hB: hex_to_seg = SEG_B;
      4'hC: hex_to_seg = SEG_C;
      4'hD: hex_to_seg = SEG_D;
      4'hE: hex_to_seg = SEG_E;
      4'hF: hex_to_seg = SEG_F;
    endcase
  endfunction

endpackage

// File: rtl/sm_debug_viewer_debouncer.sv
// Push-button conditioner: 2-FF synchroniser, stable-sample counter and a one-cycle
// press pulse on the accepted released->pressed transition.
module sm_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic press
);
  import sm_debug_viewer_pkg::*;

  localparam int unsigned   CW   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync_1, sync_2;
  db_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          press_d;

  // Synchroniser resets to the pressed level so a key held through reset never
  // counts as released; DB_ARM then waits for a genuine stable release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_1  <= 1'b0;
      sync_2  <= 1'b0;
      state_q <= DB_ARM;
      cnt_q   <= '0;
      press   <= 1'b0;
    end else begin
      sync_1  <= key_n;
      sync_2  <= sync_1;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      press   <= press_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    press_d = 1'b0;
    unique case (state_q)
      DB_ARM, DB_DOWN: begin
        if (sync_2) begin
          if (cnt_q == LAST) state_d = DB_UP;
          else               cnt_d   = cnt_q + CW'(1);
        end
      end
      DB_UP: begin
        if (!sync_2) begin
          if (cnt_q == LAST) begin
            state_d = DB_DOWN;
            press_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: state_d = DB_ARM;
    endcase
  end

endmodule

// File: rtl/sm_debug_viewer.sv
// Debug viewer top: steps a read address by keys or scan timer and shows the returned
// word on DIGITS seven-segment digits with optional leading-zero blanking.
module sm_debug_viewer #(
  parameter int unsigned DIGITS          = 6,
  parameter int unsigned ADDR_W          = 4,
  parameter int unsigned DATA_W          = 32,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned SCAN_PERIOD     = 50000000,
  parameter int unsigned BLANK_LZ        = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  key_next_n,
  input  logic                  key_prev_n,
  input  logic                  auto_en,
  input  logic                  hold,
  output logic [ADDR_W-1:0]     rd_addr,
  input  logic [DATA_W-1:0]     rd_data,
  output logic [7*DIGITS-1:0]   seg,
  output logic [ADDR_W-1:0]     addr_led,
  output logic                  step
);
  import sm_debug_viewer_pkg::*;

  localparam int unsigned TW = $clog2(SCAN_PERIOD);
  localparam int unsigned DW = 4 * DIGITS;

  logic                next_ev, prev_ev, manual, scan_tc;
  logic [TW-1:0]       timer_q, timer_d;
  logic [ADDR_W-1:0]   addr_d;
  logic [DW-1:0]       disp_q;
  logic [7*DIGITS-1:0] seg_d;
  logic                unused_data;

  assign unused_data = ^rd_data;
  assign addr_led    = rd_addr;

  sm_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_next (
    .clk   (clk),
    .rst_n (rst_n),
    .key_n (key_next_n),
    .press (next_ev)
  );

  sm_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_prev (
    .clk   (clk),
    .rst_n (rst_n),
    .key_n (key_prev_n),
    .press (prev_ev)
  );

  always_comb begin
    manual  = next_ev | prev_ev;
    scan_tc = auto_en && (timer_q == TW'(SCAN_PERIOD - 1));
    addr_d  = rd_addr;
    if (next_ev && prev_ev) addr_d = rd_addr;
    else if (next_ev)       addr_d = rd_addr + ADDR_W'(1);
    else if (prev_ev)       addr_d = rd_addr - ADDR_W'(1);
    else if (scan_tc)       addr_d = rd_addr + ADDR_W'(1);
    // A manual event restarts the scan period even when the keys cancel out.
    timer_d = '0;
    if (auto_en && !manual && !scan_tc) timer_d = timer_q + TW'(1);
  end

  always_comb begin
    logic        lead;
    logic [3:0]  nib;
    int unsigned k;
    seg_d = '1;
    lead  = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      k    = DIGITS - 1 - i;
      nib  = disp_q[4*k +: 4];
      lead = lead && (nib == 4'h0);
      if (lead && (k != 0) && (BLANK_LZ != 0)) seg_d[7*k +: 7] = SEG_BLANK;
      else                                     seg_d[7*k +: 7] = hex_to_seg(nib);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_addr <= '0;
      timer_q <= '0;
      step    <= 1'b0;
      disp_q  <= '0;
      seg     <= '1;
    end else begin
      rd_addr <= addr_d;
      timer_q <= timer_d;
      step    <= (addr_d != rd_addr);
      if (!hold) disp_q <= rd_data[DW-1:0];
      seg     <= seg_d;
    end
  end

endmodule

// File: tb/tb_sm_debug_viewer.sv
// Scoreboard bench for sm_debug_viewer: stimulus pushes expected address/cycle pairs,
// a monitor pops them on every step pulse; display contents come from an arithmetic model.
module tb_sm_debug_viewer;

  localparam int DIGITS = 6;
  localparam int ADDR_W = 4;
  localparam int DATA_W = 32;
  localparam int DEB    = 4;
  localparam int SCAN   = 8;

  localparam logic [6:0] HEX7 [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                       7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic key_next_n = 1'b1;
  logic key_prev_n = 1'b1;
  logic auto_en = 1'b0;
  logic hold = 1'b0;
  logic [ADDR_W-1:0]   rd_addr, addr_led;
  logic [DATA_W-1:0]   rd_data;
  logic [7*DIGITS-1:0] seg;
  logic                step;
  logic [31:0]         mem [16];

  typedef struct {
    logic [3:0] addr;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  int   model_addr = 0;

  assign rd_data = mem[rd_addr];

  sm_debug_viewer #(
    .DIGITS          (DIGITS),
    .ADDR_W          (ADDR_W),
    .DATA_W          (DATA_W),
    .DEBOUNCE_CYCLES (DEB),
    .SCAN_PERIOD     (SCAN),
    .BLANK_LZ        (1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_next_n (key_next_n),
    .key_prev_n (key_prev_n),
    .auto_en    (auto_en),
    .hold       (hold),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .seg        (seg),
    .addr_led   (addr_led),
    .step       (step)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Most significant nonzero nibble decides how many digits are lit.
  function automatic logic [41:0] exp_seg(input logic [31:0] w);
    logic [41:0] s;
    logic [3:0]  n;
    int          top;
    top = 0;
    for (int i = 0; i < DIGITS; i++) if (w[4*i +: 4] != 4'h0) top = i;
    for (int i = 0; i < DIGITS; i++) begin
      n = w[4*i +: 4];
      s[7*i +: 7] = (i > top) ? 7'h7F : HEX7[n];
    end
    return s;
  endfunction

  always @(negedge clk) begin
    if (rst_n && step) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_step: step=1 rd_addr=%0d with no pending expectation (cycle %0d)",
                 rd_addr, cyc);
      end else begin
        mon_e = sb.pop_front();
        check("step_addr", 64'(rd_addr), 64'(mon_e.addr));
        check("step_cycle", 64'(cyc), 64'(mon_e.cyc));
        check("addr_led", 64'(addr_led), 64'(mon_e.addr));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic set_key(input bit is_next, input logic v);
    if (is_next) key_next_n = v;
    else         key_prev_n = v;
  endtask

  task automatic push_exp(input int addr, input int at);
    exp_t ex;
    ex.addr = 4'(addr);
    ex.cyc  = at;
    sb.push_back(ex);
  endtask

  task automatic press(input bit is_next, input int glitches);
    for (int g = 0; g < glitches; g++) begin
      set_key(is_next, 1'b0);
      tick(int'($urandom_range(1, DEB - 1)));
      set_key(is_next, 1'b1);
      tick(int'($urandom_range(1, 2)));
    end
    set_key(is_next, 1'b0);
    model_addr = is_next ? (model_addr + 1) % 16 : (model_addr + 15) % 16;
    push_exp(model_addr, cyc + DEB + 3);
    tick(DEB + 6);
    set_key(is_next, 1'b1);
    tick(DEB + 6);
    check("sb_drained", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    int c, a, m;
    for (int i = 0; i < 16; i++) mem[i] = $urandom;
    mem[0] = 32'h00001234;

    tick(2);
    check("reset_addr", 64'(rd_addr), 64'd0);
    check("reset_led", 64'(addr_led), 64'd0);
    check("reset_step", 64'(step), 64'd0);
    check("reset_seg", 64'(seg), 64'h3FF_FFFF_FFFF);
    rst_n = 1'b1;
    tick(3);
    check("boot_seg", 64'(seg), 64'({7'h7F, 7'h7F, 7'h79, 7'h24, 7'h30, 7'h19}));
    check("boot_addr", 64'(rd_addr), 64'd0);
    tick(DEB + 4);

    // glitchy next press, then wrap in both directions
    press(1'b1, 3);
    check("seg_addr1", 64'(seg), 64'(exp_seg(mem[1])));
    press(1'b0, 0);
    press(1'b0, 0);
    check("wrap_prev", 64'(rd_addr), 64'd15);
    press(1'b1, 1);
    check("wrap_next", 64'(rd_addr), 64'd0);

    // both keys together cancel
    key_next_n = 1'b0;
    key_prev_n = 1'b0;
    tick(DEB + 6);
    key_next_n = 1'b1;
    key_prev_n = 1'b1;
    tick(DEB + 6);
    check("both_keys", 64'(rd_addr), 64'(model_addr));

    repeat (8) begin
      press($urandom_range(0, 1) == 1, int'($urandom_range(0, 3)));
      check("rand_addr", 64'(rd_addr), 64'(model_addr));
      check("rand_seg", 64'(seg), 64'(exp_seg(mem[model_addr])));
    end

    // auto scan with a manual next landing mid-period
    c = cyc;
    a = model_addr;
    m = int'($urandom_range(2, 6));
    auto_en = 1'b1;
    push_exp((a + 1) % 16, c + SCAN);
    push_exp((a + 2) % 16, c + 2 * SCAN);
    push_exp((a + 3) % 16, c + 2 * SCAN + m + 1);
    push_exp((a + 4) % 16, c + 3 * SCAN + m + 1);
    push_exp((a + 5) % 16, c + 4 * SCAN + m + 1);
    wait_until(c + 2 * SCAN + m + 1 - DEB - 3);
    key_next_n = 1'b0;
    tick(DEB + 6);
    key_next_n = 1'b1;
    wait_until(c + 4 * SCAN + m + 3);
    auto_en = 1'b0;
    model_addr = (a + 5) % 16;
    tick(DEB + 6);
    check("auto_drained", 64'(sb.size()), 64'd0);
    check("auto_addr", 64'(rd_addr), 64'(model_addr));

    // hold freezes the display while the address moves on
    mem[model_addr] = 32'h0000CAFE;
    mem[(model_addr + 1) % 16] = 32'h0;
    tick(3);
    check("seg_cafe", 64'(seg), 64'({7'h7F, 7'h7F, 7'h46, 7'h08, 7'h0E, 7'h06}));
    hold = 1'b1;
    tick(1);
    press(1'b1, 0);
    check("hold_addr", 64'(rd_addr), 64'(model_addr));
    check("hold_seg", 64'(seg), 64'(exp_seg(32'h0000CAFE)));
    hold = 1'b0;
    tick(2);
    check("unhold_seg", 64'(seg), 64'({7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40}));

    // reset mid-debounce with the key held through reset release
    key_next_n = 1'b0;
    tick(DEB / 2 + 2);
    rst_n = 1'b0;
    tick(2);
    check("midrst_addr", 64'(rd_addr), 64'd0);
    check("midrst_seg", 64'(seg), 64'h3FF_FFFF_FFFF);
    model_addr = 0;
    rst_n = 1'b1;
    tick(4 * DEB + 10);
    check("held_no_event", 64'(rd_addr), 64'd0);
    key_next_n = 1'b1;
    tick(DEB + 6);
    press(1'b1, 0);
    check("repress_addr", 64'(rd_addr), 64'd1);

    tick(4);
    check("final_drained", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
